board_req_queue: RTL and testbench

Requester-side companion to the 4-way round-robin board arbiter. It holds per-board packet queues, presents their non-empty status to the arbiter as a request mask, accepts the registered one-hot grant and board select back, and drains the granted queue head onto a single output stream with valid/ready handshake. It sits between the four board-facing ingress links and the shared egress path that the arbiter's board select steers.

---
 rtl/board_req_queue.sv | 105 ++++++++++
 tb/tb_board_req_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_req_queue.sv
// Four per-board packet FIFOs feeding a round-robin arbiter and draining the granted head onto one stream.
// Define BOARD_REQ_QUEUE_CHECK_EN to build the sticky grant/board_sel protocol checker behind proto_err.
module board_req_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                in_valid,
  input  logic [4*DATA_WIDTH-1:0]   in_data,
  output logic [3:0]                in_ready,
  output logic [3:0]                req_mask,
  output logic                      arb_enable,
  input  logic [3:0]                grant_mask,
  input  logic [2:0]                board_sel,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [1:0]                out_board,
  input  logic                      out_ready,
  output logic                      proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem    [4][DEPTH];
  logic [AW-1:0]         r_wr_ptr [4];
  logic [AW-1:0]         r_rd_ptr [4];
  logic [CW-1:0]         r_count  [4];

  logic [3:0]            w_push;
  logic [3:0]            w_pop;
  logic                  w_onehot;
  logic [1:0]            w_g;
  logic [DATA_WIDTH-1:0] w_head;

  always_comb begin
    in_ready = '0;
    req_mask = '0;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = (r_count[i] != CW'(DEPTH));
      req_mask[i] = (r_count[i] != '0);
    end
  end

  assign w_push   = in_valid & in_ready;
  assign w_onehot = (grant_mask != 4'd0) && ((grant_mask & (grant_mask - 4'd1)) == 4'd0);
  assign w_g      = board_sel[1:0];
  assign w_head   = r_mem[w_g][r_rd_ptr[w_g]];

  // Egress is driven purely from the registered grant and the registered queue state.
  assign out_valid  = w_onehot && (r_count[w_g] != '0);
  assign out_data   = out_valid ? w_head : '0;
  assign out_board  = w_onehot ? w_g : 2'd0;
  assign w_pop      = (out_valid && out_ready) ? (4'b0001 << w_g) : 4'b0000;
  assign arb_enable = (req_mask != 4'd0) && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CW'(1);
          2'b01:   r_count[i] <= r_count[i] - CW'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // Payload storage carries no reset; validity lives entirely in the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef BOARD_REQ_QUEUE_CHECK_EN
  logic r_proto_err;
  logic w_proto_bad;

  assign w_proto_bad = ((grant_mask != 4'd0) && !w_onehot)
                    || (w_onehot && (board_sel[2] || !grant_mask[w_g]))
                    || ((grant_mask == 4'd0) && (board_sel != 3'd7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_proto_err <= 1'b0;
    else        r_proto_err <= r_proto_err | w_proto_bad;
  end

  assign proto_err = r_proto_err;
`else
  logic w_unused_sel;
  assign w_unused_sel = board_sel[2];
  assign proto_err    = 1'b0;
`endif

endmodule

// File: tb/tb_board_req_queue.sv
// Directed bench for board_req_queue with a behavioural round-robin arbiter and per-board data scoreboard.
// Proto_err expectations follow BOARD_REQ_QUEUE_CHECK_EN.
module tb_board_req_queue;

  localparam int DW = 64;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    in_valid = '0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]    in_ready;
  logic [3:0]    req_mask;
  logic          arb_enable;
  logic [3:0]    grant_mask;
  logic [2:0]    board_sel;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_board;
  logic          out_ready = 1'b0;
  logic          proto_err;

  int nchk = 0;
  int nfail = 0;
  int pops = 0;
  int mcnt [4];
  logic [DW-1:0] sb0[$], sb1[$], sb2[$], sb3[$];

  logic [3:0] arb_grant;
  logic [1:0] arb_last;
  logic [2:0] arb_sel;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_grant = '0;
  logic [2:0] ovr_sel = '0;

  board_req_queue #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req_mask(req_mask), .arb_enable(arb_enable),
    .grant_mask(grant_mask), .board_sel(board_sel), .out_valid(out_valid),
    .out_data(out_data), .out_board(out_board), .out_ready(out_ready),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter model: starts after the last winner and skips the current grant.
  function automatic int rr_pick(input logic [3:0] req, input logic [3:0] cur, input logic [1:0] last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(last) + k) % 4;
      if (req[idx] && !cur[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_grant <= '0;
      arb_last  <= 2'd3;
    end else if (arb_enable) begin
      if (rr_pick(req_mask, arb_grant, arb_last) < 0) begin
        arb_grant <= '0;
      end else begin
        arb_grant <= 4'b0001 << rr_pick(req_mask, arb_grant, arb_last);
        arb_last  <= 2'(rr_pick(req_mask, arb_grant, arb_last));
      end
    end
  end

  always_comb begin
    arb_sel = 3'd7;
    case (arb_grant)
      4'b0001: arb_sel = 3'd0;
      4'b0010: arb_sel = 3'd1;
      4'b0100: arb_sel = 3'd2;
      4'b1000: arb_sel = 3'd3;
      default: arb_sel = 3'd7;
    endcase
  end

  assign grant_mask = ovr_en ? ovr_grant : arb_grant;
  assign board_sel  = ovr_en ? ovr_sel : arb_sel;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sb_peek(input int b, output logic [DW-1:0] d);
    d = '0;
    case (b)
      0: if (sb0.size() != 0) begin d = sb0[0]; return 1'b1; end
      1: if (sb1.size() != 0) begin d = sb1[0]; return 1'b1; end
      2: if (sb2.size() != 0) begin d = sb2[0]; return 1'b1; end
      default: if (sb3.size() != 0) begin d = sb3[0]; return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // Scoreboard fill/drain at the active edge, using the bench's own occupancy model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete();
      for (int i = 0; i < 4; i++) mcnt[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && mcnt[i] != DP) begin
          case (i)
            0: sb0.push_back(in_data[0*DW +: DW]);
            1: sb1.push_back(in_data[1*DW +: DW]);
            2: sb2.push_back(in_data[2*DW +: DW]);
            default: sb3.push_back(in_data[3*DW +: DW]);
          endcase
        end
        mcnt[i] <= mcnt[i] + ((in_valid[i] && mcnt[i] != DP) ? 1 : 0)
                           - ((out_valid && out_ready && int'(out_board) == i) ? 1 : 0);
      end
      if (out_valid && out_ready) begin
        pops <= pops + 1;
        case (out_board)
          2'd0: if (sb0.size() != 0) void'(sb0.pop_front());
          2'd1: if (sb1.size() != 0) void'(sb1.pop_front());
          2'd2: if (sb2.size() != 0) void'(sb2.pop_front());
          default: if (sb3.size() != 0) void'(sb3.pop_front());
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (rst_n && out_valid && out_ready) begin
      if (!sb_peek(int'(out_board), exp_d)) begin
        nchk++;
        nfail++;
        $error("FAIL sb_unexpected_pop: observed board %0d data %0h, expected no packet", out_board, out_data);
      end else begin
        chk("sb_data", out_data, exp_d);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; ovr_en = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'hF);
    chk("rst_req_mask", 64'(req_mask), 64'h0);
    chk("rst_arb_enable", 64'(arb_enable), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_board", 64'(out_board), 64'h0);
    chk("rst_proto_err", 64'(proto_err), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the push edge.
  task automatic push(input int b, input logic [DW-1:0] d);
    in_valid = '0;
    in_valid[b] = 1'b1;
    in_data[b*DW +: DW] = d;
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  initial begin
    int p0;
    logic exp_perr;

    // Single packet latency on board 2.
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(2, 64'hA5);
    @(negedge clk);
    chk("lat_req_mask", 64'(req_mask), 64'h4);
    chk("lat_arb_enable", 64'(arb_enable), 64'h1);
    chk("lat_valid_early", 64'(out_valid), 64'h0);
    @(negedge clk);
    chk("lat_out_valid", 64'(out_valid), 64'h1);
    chk("lat_out_data", out_data, 64'hA5);
    chk("lat_out_board", 64'(out_board), 64'h2);
    @(negedge clk);
    chk("lat_req_after_pop", 64'(req_mask), 64'h0);
    chk("lat_valid_after_pop", 64'(out_valid), 64'h0);

    // Fill board 1, then push and pop together while full.
    do_reset();
    @(posedge clk); #1;
    p0 = pops;
    for (int k = 1; k <= 4; k++) push(1, 64'(k));
    @(negedge clk);
    chk("full_in_ready1", 64'(in_ready[1]), 64'h0);
    chk("full_out_data", out_data, 64'h1);
    @(posedge clk); #1;
    in_valid = 4'b0010; in_data[1*DW +: DW] = 64'h99; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("full_pop_count", 64'(pops - p0), 64'h1);
    chk("full_in_ready_after", 64'(in_ready[1]), 64'h1);
    chk("full_req_after", 64'(req_mask), 64'h2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("full_drained_pops", 64'(pops - p0), 64'h4);
    chk("full_drained_req", 64'(req_mask), 64'h0);

    // Four boards, three packets each, drained at one per cycle.
    do_reset();
    @(posedge clk); #1;
    p0 = pops;
    for (int r = 0; r < 3; r++) begin
      in_valid = 4'hF;
      for (int b = 0; b < 4; b++) in_data[b*DW +: DW] = 64'(16 * b + r + 256);
      @(posedge clk); #1;
      in_valid = '0;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_valid", 64'(out_valid), 64'h1);
      chk("rr_board", 64'(out_board), 64'(k % 4));
    end
    @(negedge clk);
    chk("rr_total", 64'(pops - p0), 64'd12);
    chk("rr_empty", 64'(req_mask), 64'h0);

    // Single active board alternates grant and idle.
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) push(3, 64'(k + 64'h300));
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("alt_valid", 64'(out_valid), 64'((k % 2) == 0));
      if ((k % 2) == 0) chk("alt_board", 64'(out_board), 64'h3);
    end
    @(negedge clk);
    chk("alt_empty", 64'(req_mask), 64'h0);

    // Back-pressure holds the presented packet and grant.
    do_reset();
    @(posedge clk); #1;
    push(0, 64'h11);
    push(0, 64'h22);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_arb_enable", 64'(arb_enable), 64'h0);
      chk("hold_grant", 64'(grant_mask), 64'h1);
      chk("hold_data", out_data, 64'h11);
      chk("hold_board", 64'(out_board), 64'h0);
    end
    p0 = pops;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_single_pop", 64'(pops - p0), 64'h1);
    chk("hold_req_left", 64'(req_mask), 64'h1);

    // Protocol checker, then asynchronous reset mid-transfer.
`ifdef BOARD_REQ_QUEUE_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    @(posedge clk); #1;
    ovr_en = 1'b1; ovr_grant = 4'b0010; ovr_sel = 3'd0;
    @(negedge clk);
    chk("perr_before_edge", 64'(proto_err), 64'h0);
    @(posedge clk); #1;
    ovr_en = 1'b0;
    @(negedge clk);
    chk("perr_set", 64'(proto_err), 64'(exp_perr));
    repeat (3) @(negedge clk);
    chk("perr_sticky", 64'(proto_err), 64'(exp_perr));
    chk("mid_valid", 64'(out_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'h0);
    chk("async_in_ready", 64'(in_ready), 64'hF);
    chk("async_req_mask", 64'(req_mask), 64'h0);
    chk("async_out_data", out_data, 64'h0);
    chk("async_proto_err", 64'(proto_err), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(1, 64'h5A);
    @(negedge clk);
    chk("post_rst_valid_early", 64'(out_valid), 64'h0);
    chk("post_rst_req", 64'(req_mask), 64'h2);
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'h1);
    chk("post_rst_data", out_data, 64'h5A);
    @(negedge clk);
    chk("post_rst_drained", 64'(req_mask), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "simulation time limit reached");
  end

endmodule
